// File: rtl/tdc_pkg.sv
// tdc_pkg: shared widths, TDC core state encodings and sequencer states.
package tdc_pkg;
    localparam int MEAS_W   = 40;
    localparam int FLAG_BIT = MEAS_W;
    localparam int RES_W    = MEAS_W + 1;

    typedef enum logic [1:0] {
        CORE_IDLE      = 2'd0,
        CORE_ARMED     = 2'd1,
        CORE_MEASURING = 2'd2,
        CORE_DONE      = 2'd3
    } core_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DONE
    } seq_state_t;
endpackage

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: single-clock result FIFO; head entry is presented directly from storage.
module tdc_result_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/tdc_sequencer.sv
// tdc_sequencer: burst controller arming the TDC core and queueing results for the host.
// Define TDC_SEQ_TIMEOUT_EN to add the hung-measurement abort, flagged entries and miss_count.
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 300000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_burst_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_tdc_arm,
    output logic              o_tdc_rst_n,
    input  logic [1:0]        i_tdc_state,
    input  logic [MEAS_W-1:0] i_tdc_measurement,
    input  logic              i_tdc_meas_valid,
    output logic [RES_W-1:0]  o_res_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [7:0]        o_miss_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       r_state;
    logic [7:0]       r_remaining;
    logic             r_busy;
    logic             r_done;
    logic             r_tdc_arm;
    logic             r_tdc_rst_n;
    logic             w_meas_in;
    logic             w_timeout;
    logic             w_event;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [RES_W-1:0] w_push_data;

    assign w_meas_in   = (r_state == S_WAIT) && i_tdc_meas_valid;
    assign w_event     = w_meas_in || w_timeout;
    assign w_push      = w_event && !w_full;
    assign w_push_data = {w_timeout, w_meas_in ? i_tdc_measurement : MEAS_W'(0)};

`ifdef TDC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic [7:0]    r_miss;

    // A measurement arriving on the final cycle takes priority over the abort.
    assign w_timeout    = (r_state == S_WAIT) && !i_tdc_meas_valid && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign o_miss_count = r_miss;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
            r_miss    <= '0;
        end else begin
            r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + TW'(1) : '0;
            if (w_timeout && r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
        end
    end
`else
    assign w_timeout    = 1'b0;
    assign o_miss_count = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tdc_arm   <= 1'b0;
            r_tdc_rst_n <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_tdc_arm   <= 1'b0;
            r_tdc_rst_n <= !w_timeout;
            case (r_state)
                S_IDLE: begin
                    r_busy <= i_start;
                    if (i_start) begin
                        r_remaining <= i_burst_len;
                        r_state     <= (i_burst_len == 8'd0) ? S_DONE : S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_tdc_state == CORE_IDLE && w_count != CW'(FIFO_DEPTH)) begin
                        r_tdc_arm <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_event) begin
                        r_remaining <= r_remaining - 8'd1;
                        r_state     <= (r_remaining == 8'd1) ? S_DONE : S_ARM;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_tdc_arm   = r_tdc_arm;
    assign o_tdc_rst_n = r_tdc_rst_n;
    assign o_res_valid = !w_empty;

    tdc_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (i_res_ready),
        .i_data  (w_push_data),
        .o_data  (o_res_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule
